// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - scaled, animated, flippable sprite pixel generator
// Drives an external sprite ROM and returns pixels aligned to hcount/vcount + ROM_LATENCY + 2.
module sprite_blitter #(
  parameter int          WIDTH        = 16,
  parameter int          HEIGHT       = 16,
  parameter int          SCALE_LOG2   = 0,
  parameter int          NUM_FRAMES   = 4,
  parameter int          FRAME_PERIOD = 8,
  parameter int          ADDR_W       = 16,
  parameter int          ROM_LATENCY  = 1,
  parameter logic [11:0] TRANSP_KEY   = 12'h000
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic              flip_in,
  input  logic              frame_tick_in,
  input  logic              anim_en_in,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [11:0]       rom_data_in,
  output logic [11:0]       pixel_out,
  output logic              hit_out
);

  localparam int SW     = WIDTH << SCALE_LOG2;
  localparam int SH     = HEIGHT << SCALE_LOG2;
  localparam int FIDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int TCNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam logic [31:0] FRAME_SZ = 32'(WIDTH * HEIGHT);

  logic [10:0]        x_l_q, x_l_d;
  logic [9:0]         y_l_q, y_l_d;
  logic               flip_l_q, flip_l_d;
  logic [FIDX_W-1:0]  fidx_q, fidx_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [ROM_LATENCY:0] v_q, v_d;
  logic [11:0]        pixel_q, pixel_d;
  logic               hit_q, hit_d;

  logic [11:0]        h12, v12, xs12, ys12, h_off, v_off, col_raw, col, row;
  logic               in_box;
  logic [ADDR_W-1:0]  addr;

  // Position and animation state only move on the blanking tick, so a frame is never torn.
  always_comb begin
    x_l_d    = x_l_q;
    y_l_d    = y_l_q;
    flip_l_d = flip_l_q;
    fidx_d   = fidx_q;
    tcnt_d   = tcnt_q;
    if (frame_tick_in) begin
      x_l_d    = x_in;
      y_l_d    = y_in;
      flip_l_d = flip_in;
      if (anim_en_in) begin
        if (tcnt_q == TCNT_W'(FRAME_PERIOD - 1)) begin
          tcnt_d = '0;
          fidx_d = (fidx_q == FIDX_W'(NUM_FRAMES - 1)) ? '0 : fidx_q + 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
    end
  end

  // 12-bit compares keep x_l+SW from wrapping past the 11-bit counter range.
  always_comb begin
    h12     = {1'b0, hcount_in};
    v12     = {2'b00, vcount_in};
    xs12    = {1'b0, x_l_q};
    ys12    = {2'b00, y_l_q};
    in_box  = (h12 >= xs12) && (h12 < xs12 + 12'(SW)) &&
              (v12 >= ys12) && (v12 < ys12 + 12'(SH));
    h_off   = h12 - xs12;
    v_off   = v12 - ys12;
    col_raw = h_off >> SCALE_LOG2;
    col     = flip_l_q ? (12'(WIDTH - 1) - col_raw) : col_raw;
    row     = v_off >> SCALE_LOG2;
    addr    = ADDR_W'(32'(fidx_q) * FRAME_SZ + 32'(row) * 32'(WIDTH) + 32'(col));
  end

  always_comb begin
    rom_addr_d = in_box ? addr : rom_addr_q;
    v_d        = {v_q[ROM_LATENCY-1:0], in_box};
    if (v_q[ROM_LATENCY] && (rom_data_in != TRANSP_KEY)) begin
      pixel_d = rom_data_in;
      hit_d   = 1'b1;
    end else begin
      pixel_d = '0;
      hit_d   = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      x_l_q      <= '0;
      y_l_q      <= '0;
      flip_l_q   <= 1'b0;
      fidx_q     <= '0;
      tcnt_q     <= '0;
      rom_addr_q <= '0;
      v_q        <= '0;
      pixel_q    <= '0;
      hit_q      <= 1'b0;
    end else begin
      x_l_q      <= x_l_d;
      y_l_q      <= y_l_d;
      flip_l_q   <= flip_l_d;
      fidx_q     <= fidx_d;
      tcnt_q     <= tcnt_d;
      rom_addr_q <= rom_addr_d;
      v_q        <= v_d;
      pixel_q    <= pixel_d;
      hit_q      <= hit_d;
    end
  end

  assign rom_addr_out = rom_addr_q;
  assign pixel_out    = pixel_q;
  assign hit_out      = hit_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed bench for sprite_blitter at scale 1x and 2x
// ROM models return the low 12 address bits one edge after the address register.
module tb_sprite_blitter;

  localparam logic [10:0] OFF_H = 11'd2000;
  localparam logic [9:0]  OFF_V = 10'd1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount, x_in;
  logic [9:0]  vcount, y_in;
  logic        flip, tick, anim_en;
  logic [15:0] addr0, addr1;
  logic [11:0] rom0, rom1, pix0, pix1;
  logic        hit0, hit1;

  int checks = 0;
  int errors = 0;

  logic [15:0] a0, a1;
  logic [11:0] p0, p1, pmid0;
  logic        h0, h1;

  always #5 clk = ~clk;

  sprite_blitter #(.SCALE_LOG2(0)) dut0 (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .x_in(x_in), .y_in(y_in), .flip_in(flip), .frame_tick_in(tick), .anim_en_in(anim_en),
    .rom_addr_out(addr0), .rom_data_in(rom0), .pixel_out(pix0), .hit_out(hit0)
  );

  sprite_blitter #(.SCALE_LOG2(1)) dut1 (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .x_in(x_in), .y_in(y_in), .flip_in(flip), .frame_tick_in(tick), .anim_en_in(anim_en),
    .rom_addr_out(addr1), .rom_data_in(rom1), .pixel_out(pix1), .hit_out(hit1)
  );

  always_ff @(posedge clk) begin
    rom0 <= addr0[11:0];
    rom1 <= addr1[11:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle probe: address captured after the sampling edge, pixel after the third edge.
  task automatic probe(input logic [10:0] h, input logic [9:0] v);
    @(negedge clk); hcount = h; vcount = v;
    @(posedge clk);
    @(negedge clk); hcount = OFF_H; vcount = OFF_V; a0 = addr0; a1 = addr1;
    @(posedge clk); #1 pmid0 = pix0;
    @(posedge clk); #1 p0 = pix0; h0 = hit0; p1 = pix1; h1 = hit1;
  endtask

  task automatic frame_tick(input logic [10:0] x, input logic [9:0] y, input logic f);
    @(negedge clk); x_in = x; y_in = y; flip = f; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) frame_tick(x_in, y_in, flip);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; hcount = OFF_H; vcount = OFF_V; x_in = '0; y_in = '0;
    flip = 1'b0; tick = 1'b0; anim_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pix", pix0, 0);
    check("reset_hit", hit0, 0);
    check("reset_addr", addr0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Unscaled sprite at (100,50)
    frame_tick(11'd100, 10'd50, 1'b0);
    probe(11'd100, 10'd50);
    check("origin_transp_pix", p0, 12'h000);
    check("origin_transp_hit", h0, 0);
    probe(11'd101, 10'd50);
    check("lat_early", pmid0, 12'h000);
    check("px101_pix", p0, 12'h001);
    check("px101_hit", h0, 1);
    @(posedge clk); #1 check("lat_late", pix0, 12'h000);
    probe(11'd115, 10'd65);
    check("px_last_addr", a0, 16'd255);
    check("px_last_pix", p0, 12'h0FF);
    probe(11'd116, 10'd65);
    check("right_out_pix", p0, 0);
    check("right_out_hit", h0, 0);
    check("addr_hold", a0, 16'd255);
    probe(11'd99, 10'd50);
    check("left_out_hit", h0, 0);

    // 2x magnification at origin (dut1)
    frame_tick(11'd0, 10'd0, 1'b0);
    probe(11'd1, 10'd0);
    check("s1_h1_addr", a1, 0);
    check("u_h1_pix", p0, 12'h001);
    probe(11'd2, 10'd0);
    check("s1_h2_addr", a1, 1);
    check("s1_h2_pix", p1, 12'h001);
    probe(11'd3, 10'd0);
    check("s1_h3_pix", p1, 12'h001);
    probe(11'd32, 10'd0);
    check("s1_h32_hit", h1, 0);
    probe(11'd31, 10'd31);
    check("s1_corner_addr", a1, 16'd255);
    check("s1_corner_pix", p1, 12'h0FF);

    // Horizontal flip
    frame_tick(11'd100, 10'd50, 1'b1);
    probe(11'd100, 10'd50);
    check("flip_left_addr", a0, 16'd15);
    check("flip_left_pix", p0, 12'h00F);
    probe(11'd115, 10'd50);
    check("flip_right_addr", a0, 0);
    check("flip_right_hit", h0, 0);
    probe(11'd101, 10'd51);
    check("flip_r1_pix", p0, 12'h01E);
    frame_tick(11'd100, 10'd50, 1'b0);

    // Animation: tcnt is still 0 because anim_en was low for all earlier ticks
    anim_en = 1'b1;
    ticks(7);
    probe(11'd101, 10'd50);
    check("anim_t7", p0, 12'h001);
    ticks(1);
    probe(11'd101, 10'd50);
    check("anim_t8", p0, 12'h101);
    ticks(23);
    probe(11'd101, 10'd50);
    check("anim_t31", p0, 12'h301);
    ticks(1);
    probe(11'd101, 10'd50);
    check("anim_wrap", p0, 12'h001);
    anim_en = 1'b0;
    ticks(8);
    probe(11'd101, 10'd50);
    check("anim_frozen", p0, 12'h001);
    anim_en = 1'b1;
    ticks(8);
    anim_en = 1'b0;
    probe(11'd101, 10'd50);
    check("anim_f1", p0, 12'h101);

    // No tearing: x_in moves without a tick
    @(negedge clk); x_in = 11'd200;
    probe(11'd101, 10'd50);
    check("tear_old", p0, 12'h101);
    probe(11'd201, 10'd50);
    check("tear_new_hidden", h0, 0);
    ticks(1);
    probe(11'd201, 10'd50);
    check("latched_new", p0, 12'h101);
    probe(11'd101, 10'd50);
    check("latched_old_gone", h0, 0);

    // Reset mid-sprite
    @(negedge clk); hcount = 11'd201; vcount = 10'd50;
    repeat (3) @(posedge clk);
    #1 check("pre_reset_pix", pix0, 12'h101);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_pix", pix0, 0);
    check("midreset_hit", hit0, 0);
    @(negedge clk); rst_n = 1'b1; hcount = OFF_H; vcount = OFF_V;
    probe(11'd1, 10'd0);
    check("post_reset_pix", p0, 12'h001);
    probe(11'd3, 10'd0);
    check("post_reset_s1", p1, 12'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
